// File: rtl/ps_param_keeper_pkg.sv
// Shared types and helpers for the PacketStream parameter keeper pipeline.
// Entry layout is {dat, eop, sop, pos, param}; widths come from the instantiating module.
package ps_param_keeper_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_PWIDTH = 8;
    localparam int DEF_CWIDTH = 16;
    localparam int FLAG_W     = 2;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    function automatic int entry_w(input int dw, input int pw, input int cw);
        return dw + pw + cw + FLAG_W;
    endfunction

    localparam int ENTRY_W = entry_w(DEF_DWIDTH, DEF_PWIDTH, DEF_CWIDTH);

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
        logic [31:0] max_val;
        if (width >= 32) begin
            max_val = '1;
        end else begin
            max_val = (32'd1 << width) - 32'd1;
        end
        if (cnt >= max_val) begin
            return max_val;
        end
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/ps_skid_buffer.sv
// Generic 2-entry registered buffer: main register drives the outputs, skid register
// absorbs the beat accepted while the consumer stalls. Ready and valid are both flops.
module ps_skid_buffer
    import ps_param_keeper_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_val,
    output logic             i_rdy,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_val,
    input  logic             o_rdy
);

    buf_state_t       state;
    buf_state_t       state_next;
    logic [WIDTH-1:0] main_dat;
    logic [WIDTH-1:0] skid_dat;
    logic             main_val;
    logic             rdy_q;
    logic             accept;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign accept = i_val & rdy_q;
    assign i_rdy  = rdy_q;
    assign o_val  = main_val;
    assign o_dat  = main_dat;

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    load_main  = 1'b1;
                    state_next = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && o_rdy) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = BUF_FULL;
                end else if (o_rdy) begin
                    state_next = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (o_rdy) begin
                    main_from_skid = 1'b1;
                    state_next     = BUF_ONE;
                end
            end
            default: begin
                state_next = BUF_EMPTY;
            end
        endcase
    end

    // Ready and valid are registered from the next state so neither side sees a comb path.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= BUF_EMPTY;
            rdy_q    <= 1'b0;
            main_val <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else begin
            state    <= state_next;
            rdy_q    <= (state_next != BUF_FULL);
            main_val <= (state_next != BUF_EMPTY);
            if (load_main) begin
                main_dat <= i_dat;
            end else if (main_from_skid) begin
                main_dat <= skid_dat;
            end
            if (load_skid) begin
                skid_dat <= i_dat;
            end
        end
    end

endmodule

// File: rtl/ps_param_keeper_pipe.sv
// PacketStream parameter keeper: tags each accepted beat with its packet's parameters,
// SOP flag and beat index, then passes it through a fully registered skid buffer.
module ps_param_keeper_pipe
    import ps_param_keeper_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PWIDTH-1:0] desired_param,
    input  logic [DWIDTH-1:0] i_dat,
    input  logic              i_val,
    input  logic              i_eop,
    output logic              i_rdy,
    output logic [DWIDTH-1:0] o_dat,
    output logic              o_val,
    output logic              o_eop,
    output logic              o_sop,
    output logic [CWIDTH-1:0] o_pos,
    output logic [PWIDTH-1:0] o_param,
    input  logic              o_rdy
);

    localparam int EW = entry_w(DWIDTH, PWIDTH, CWIDTH);

    typedef struct packed {
        logic [DWIDTH-1:0] dat;
        logic              eop;
        logic              sop;
        logic [CWIDTH-1:0] pos;
        logic [PWIDTH-1:0] param;
    } entry_t;

    logic              sop_flag;
    logic [CWIDTH-1:0] cnt;
    logic [CWIDTH-1:0] cnt_next;
    logic [PWIDTH-1:0] held_param;
    logic              accept;
    entry_t            in_entry;
    entry_t            out_entry;
    logic [EW-1:0]     out_vec;

    assign accept   = i_val & i_rdy;
    assign cnt_next = CWIDTH'(sat_inc(32'(cnt), CWIDTH));

    always_comb begin
        in_entry.dat   = i_dat;
        in_entry.eop   = i_eop;
        in_entry.sop   = sop_flag;
        in_entry.pos   = sop_flag ? '0 : cnt;
        in_entry.param = sop_flag ? desired_param : held_param;
    end

    // Parameters are latched only on the first beat, so later desired_param changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sop_flag   <= 1'b1;
            cnt        <= '0;
            held_param <= '0;
        end else if (accept) begin
            if (sop_flag) begin
                held_param <= desired_param;
            end
            cnt      <= i_eop ? '0 : cnt_next;
            sop_flag <= i_eop;
        end
    end

    ps_skid_buffer #(
        .WIDTH (EW)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_dat   (in_entry),
        .i_val   (i_val),
        .i_rdy   (i_rdy),
        .o_dat   (out_vec),
        .o_val   (o_val),
        .o_rdy   (o_rdy)
    );

    assign out_entry = out_vec;
    assign o_dat     = out_entry.dat;
    assign o_eop     = out_entry.eop;
    assign o_sop     = out_entry.sop;
    assign o_pos     = out_entry.pos;
    assign o_param   = out_entry.param;

endmodule

// File: tb/tb_ps_param_keeper_pipe.sv
// Bench for ps_param_keeper_pipe: directed scenarios plus randomized backpressure
// against a queue-based packet model; a CWIDTH=2 twin exercises beat-index saturation.
module tb_ps_param_keeper_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  desired_param;
    logic [7:0]  i_dat;
    logic        i_val;
    logic        i_eop;
    logic        o_rdy;

    logic        i_rdy, o_val, o_eop, o_sop;
    logic [7:0]  o_dat, o_param;
    logic [15:0] o_pos;

    logic        i_rdy_s, o_val_s, o_eop_s, o_sop_s;
    logic [7:0]  o_dat_s, o_param_s;
    logic [1:0]  o_pos_s;

    typedef struct {
        logic [7:0]  dat;
        logic        eop;
        logic        sop;
        logic [15:0] pos;
        logic [1:0]  pos_s;
        logic [7:0]  param;
    } exp_t;

    exp_t       q[$];
    int         m_idx;
    logic [7:0] m_param;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    ps_param_keeper_pipe #(.DWIDTH(8), .PWIDTH(8), .CWIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .desired_param(desired_param),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_sop(o_sop),
        .o_pos(o_pos), .o_param(o_param), .o_rdy(o_rdy)
    );

    ps_param_keeper_pipe #(.DWIDTH(8), .PWIDTH(8), .CWIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .desired_param(desired_param),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy_s),
        .o_dat(o_dat_s), .o_val(o_val_s), .o_eop(o_eop_s), .o_sop(o_sop_s),
        .o_pos(o_pos_s), .o_param(o_param_s), .o_rdy(o_rdy)
    );

    // Drive one cycle of inputs at the falling edge and advance the packet model by what
    // the coming rising edge will do, then wait for the next falling edge.
    task automatic tick(input logic v, input logic e, input logic [7:0] d,
                        input logic [7:0] p, input logic ordy);
        exp_t ent;
        i_val = v; i_eop = e; i_dat = d; desired_param = p; o_rdy = ordy;
        if (!reset_n) begin
            q.delete();
            m_idx = 0;
        end else begin
            if (o_val && ordy && q.size() > 0) void'(q.pop_front());
            if (v && i_rdy) begin
                if (m_idx == 0) m_param = p;
                ent.dat   = d;
                ent.eop   = e;
                ent.sop   = (m_idx == 0);
                ent.pos   = (m_idx > 65535) ? 16'hFFFF : 16'(m_idx);
                ent.pos_s = (m_idx > 3) ? 2'd3 : 2'(m_idx);
                ent.param = m_param;
                q.push_back(ent);
                m_idx = e ? 0 : m_idx + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [33:0] exp_pl;
        reset_n = 1'b0; i_val = 1'b1; i_eop = 1'b0; o_rdy = 1'b1;
        i_dat = 8'hEE; desired_param = 8'hDD;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if ({i_rdy, o_val} !== 2'b00) $display("[TB] FAIL reset_hold_hs: got %b expected 00", {i_rdy, o_val});
            else n_pass++;
            n_checks++;
            if ({o_dat, o_eop, o_sop, o_pos, o_param} !== 34'h0)
                $display("[TB] FAIL reset_hold_payload: got %h expected 0", {o_dat, o_eop, o_sop, o_pos, o_param});
            else n_pass++;
        end
        q.delete(); m_idx = 0;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({i_rdy, o_val} !== 2'b10) $display("[TB] FAIL reset_release: got %b expected 10", {i_rdy, o_val});
        else n_pass++;
        tick(1'b1, 1'b1, 8'h33, 8'h5A, 1'b1);
        exp_pl = {8'h33, 1'b1, 1'b1, 16'd0, 8'h5A};
        n_checks++;
        if (!o_val || {o_dat, o_eop, o_sop, o_pos, o_param} !== exp_pl)
            $display("[TB] FAIL first_beat: got val=%b %h expected val=1 %h", o_val, {o_dat, o_eop, o_sop, o_pos, o_param}, exp_pl);
        else n_pass++;
        tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        n_checks++;
        if (o_val !== 1'b0) $display("[TB] FAIL first_drain: got o_val=%b expected 0", o_val);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [7:0]  params [3];
        logic [7:0]  dat [12];
        logic [33:0] exp_pl;
        int          j;
        params[0] = 8'hA1; params[1] = 8'hB2; params[2] = 8'hC3;
        foreach (dat[i]) dat[i] = 8'($urandom);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                j = k - 1;
                exp_pl = {dat[j], (j % 4) == 3, (j % 4) == 0, 16'(j % 4), params[j / 4]};
                n_checks++;
                if ({o_val, i_rdy} !== 2'b11 || {o_dat, o_eop, o_sop, o_pos, o_param} !== exp_pl)
                    $display("[TB] FAIL stream_beat%0d: got val=%b rdy=%b %h expected val=1 rdy=1 %h",
                             j, o_val, i_rdy, {o_dat, o_eop, o_sop, o_pos, o_param}, exp_pl);
                else n_pass++;
            end
            if (k < 12) tick(1'b1, (k % 4) == 3, dat[k], ((k % 4) == 0) ? params[k / 4] : 8'($urandom), 1'b1);
            else        tick(1'b0, 1'b0, 8'h00, 8'($urandom), 1'b1);
        end
        n_checks++;
        if (o_val !== 1'b0) $display("[TB] FAIL stream_drain: got o_val=%b expected 0", o_val);
        else n_pass++;
    endtask

    task automatic test_single_beat();
        logic [7:0]  dat [16];
        logic [33:0] exp_pl;
        foreach (dat[i]) dat[i] = 8'($urandom);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                exp_pl = {dat[k-1], 1'b1, 1'b1, 16'd0, 8'(k)};
                n_checks++;
                if (!o_val || {o_dat, o_eop, o_sop, o_pos, o_param} !== exp_pl)
                    $display("[TB] FAIL single_beat%0d: got val=%b %h expected val=1 %h",
                             k, o_val, {o_dat, o_eop, o_sop, o_pos, o_param}, exp_pl);
                else n_pass++;
            end
            if (k < 16) tick(1'b1, 1'b1, dat[k], 8'(k + 1), 1'b1);
            else        tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
    endtask

    task automatic test_saturation();
        int         idx [9];
        logic       eop [9];
        logic [7:0] par [9];
        logic [1:0] exp_s;
        for (int k = 0; k < 9; k++) begin
            idx[k] = (k < 7) ? k : k - 7;
            eop[k] = (k == 6) || (k == 8);
            par[k] = (k < 7) ? 8'h10 : 8'h20;
        end
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                exp_s = (idx[k-1] > 3) ? 2'd3 : 2'(idx[k-1]);
                n_checks++;
                if ({o_val_s, o_pos_s, o_sop_s, o_eop_s, o_param_s} !== {1'b1, exp_s, idx[k-1] == 0, eop[k-1], par[k-1]})
                    $display("[TB] FAIL sat_beat%0d: got val=%b pos=%0d sop=%b eop=%b par=%h expected pos=%0d par=%h",
                             k - 1, o_val_s, o_pos_s, o_sop_s, o_eop_s, o_param_s, exp_s, par[k-1]);
                else n_pass++;
                n_checks++;
                if (o_pos !== 16'(idx[k-1]))
                    $display("[TB] FAIL wide_pos%0d: got %0d expected %0d", k - 1, o_pos, idx[k-1]);
                else n_pass++;
            end
            if (k < 9) tick(1'b1, eop[k], 8'($urandom), (idx[k] == 0) ? par[k] : 8'($urandom), 1'b1);
            else       tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        logic [33:0] exp_pl;
        tick(1'b1, 1'b0, 8'h01, 8'h44, 1'b0);
        tick(1'b1, 1'b0, 8'h02, 8'($urandom), 1'b0);
        tick(1'b1, 1'b0, 8'h03, 8'($urandom), 1'b0);
        n_checks++;
        if ({i_rdy, o_val} !== 2'b01) $display("[TB] FAIL midrst_full: got %b expected 01", {i_rdy, o_val});
        else n_pass++;
        reset_n = 1'b0;
        tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++;
        if ({i_rdy, o_val} !== 2'b00) $display("[TB] FAIL midrst_flush: got %b expected 00", {i_rdy, o_val});
        else n_pass++;
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        n_checks++;
        if ({i_rdy, o_val} !== 2'b10) $display("[TB] FAIL midrst_release: got %b expected 10", {i_rdy, o_val});
        else n_pass++;
        tick(1'b1, 1'b0, 8'h9C, 8'h77, 1'b1);
        exp_pl = {8'h9C, 1'b0, 1'b1, 16'd0, 8'h77};
        n_checks++;
        if (!o_val || {o_dat, o_eop, o_sop, o_pos, o_param} !== exp_pl)
            $display("[TB] FAIL midrst_sop: got val=%b %h expected val=1 %h", o_val, {o_dat, o_eop, o_sop, o_pos, o_param}, exp_pl);
        else n_pass++;
        tick(1'b1, 1'b1, 8'h9D, 8'h11, 1'b1);
        exp_pl = {8'h9D, 1'b1, 1'b0, 16'd1, 8'h77};
        n_checks++;
        if (!o_val || {o_dat, o_eop, o_sop, o_pos, o_param} !== exp_pl)
            $display("[TB] FAIL midrst_eop: got val=%b %h expected val=1 %h", o_val, {o_dat, o_eop, o_sop, o_pos, o_param}, exp_pl);
        else n_pass++;
        tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_backpressure();
        int   pkts_sent = 0;
        int   beat      = 0;
        int   pkt_len   = $urandom_range(1, 20);
        int   cycles    = 0;
        int   mism      = 0;
        logic v, e, acc;
        while ((pkts_sent < 1000 || q.size() > 0) && cycles < 60000) begin
            n_checks++;
            if ({i_rdy, o_val, i_rdy_s, o_val_s} !== {{(q.size() < 2), (q.size() != 0)}, {(q.size() < 2), (q.size() != 0)}}) begin
                mism++;
                if (mism < 10) $display("[TB] FAIL bp_handshake@%0d: got rdy=%b val=%b rdy_s=%b val_s=%b expected occupancy %0d",
                                        cycles, i_rdy, o_val, i_rdy_s, o_val_s, q.size());
            end else n_pass++;
            if (o_val && q.size() > 0) begin
                n_checks++;
                if ({o_dat, o_eop, o_sop, o_pos, o_param, o_pos_s, o_param_s} !==
                    {q[0].dat, q[0].eop, q[0].sop, q[0].pos, q[0].param, q[0].pos_s, q[0].param}) begin
                    mism++;
                    if (mism < 10) $display("[TB] FAIL bp_beat@%0d: got %h/%0d/%h expected %h/%0d/%h", cycles,
                                            {o_dat, o_eop, o_sop, o_pos, o_param}, o_pos_s, o_param_s,
                                            {q[0].dat, q[0].eop, q[0].sop, q[0].pos, q[0].param}, q[0].pos_s, q[0].param);
                end else n_pass++;
            end
            v   = (pkts_sent < 1000) && ($urandom_range(0, 3) != 0);
            e   = (beat == pkt_len - 1);
            acc = v && i_rdy;
            tick(v, e, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            if (acc) begin
                if (e) begin
                    pkts_sent++;
                    beat    = 0;
                    pkt_len = $urandom_range(1, 20);
                end else begin
                    beat++;
                end
            end
            cycles++;
        end
        n_checks++;
        if (cycles >= 60000) $display("[TB] FAIL bp_timeout: got %0d packets and %0d queued expected 1000 and 0", pkts_sent, q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_single_beat();
        test_saturation();
        test_mid_reset();
        test_backpressure();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
